// File: rtl/soc_system_gpio_in_capture_if.sv
// Avalon-MM slave bus of the GPIO input capture block (address/strobes/data).
// readdata is registered by the slave and valid one clock after an accepted read.
interface soc_system_gpio_in_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_gpio_in_capture.sv
// Input PIO: 2-flop sync, optional debounce (GPIO_IN_DEBOUNCE_EN), edge capture (W1C), masked level irq.
// Avalon-MM slave with zero wait states and a fixed read latency of 1.
module soc_system_gpio_in_capture #(
  parameter int WIDTH           = 24,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  soc_system_gpio_in_capture_if.slave avs,
  input  logic [WIDTH-1:0]            in_port,
  output logic                        irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_CAP  = 2'd2;
  localparam logic [1:0] ADDR_SEL  = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] wdat, clr, edge_det;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic [1:0]       prime_cnt_q, prime_cnt_d;
  logic             primed, prime_en;
  logic             rd_acc, wr_acc;
  logic             unused_wdata;

  assign rd_acc       = avs.chipselect & ~avs.read_n;
  assign wr_acc       = avs.chipselect & ~avs.write_n;
  assign wdat         = avs.writedata[WIDTH-1:0];
  assign unused_wdata = ^avs.writedata;
  assign primed       = (prime_cnt_q == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] hist0_q, hist1_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] agree_hi, agree_lo;
  logic [1:0]       ticks_q, ticks_d;

  assign tick = (presc_q == PW'(DEBOUNCE_CYCLES - 1));

  // The 3-sample window is the two stored samples plus the one shifting in on this tick.
  assign agree_hi = hist1_q & hist0_q & sync2_q;
  assign agree_lo = ~(hist1_q | hist0_q | sync2_q);

  always_comb begin
    presc_d  = tick ? '0 : presc_q + PW'(1);
    ticks_d  = (tick && ticks_q != 2'd3) ? ticks_q + 2'd1 : ticks_q;
    stable_d = stable_q;
    if (tick) begin
      stable_d = (stable_q | agree_hi) & ~agree_lo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      ticks_q  <= '0;
      hist0_q  <= '0;
      hist1_q  <= '0;
      stable_q <= '0;
    end else begin
      presc_q  <= presc_d;
      ticks_q  <= ticks_d;
      stable_q <= stable_d;
      if (tick) begin
        hist1_q <= hist0_q;
        hist0_q <= sync2_q;
      end
    end
  end

  assign stable   = stable_q;
  // Priming cycles only start once the history holds real samples.
  assign prime_en = (ticks_q == 2'd3);
`else
  logic unused_dbc;

  assign unused_dbc = ^DEBOUNCE_CYCLES;
  assign stable     = sync2_q;
  assign prime_en   = 1'b1;
`endif

  always_comb begin
    prime_cnt_d = prime_cnt_q;
    if (prime_en && !primed) begin
      prime_cnt_d = prime_cnt_q + 2'd1;
    end

    edge_det = '0;
    if (primed) begin
      edge_det = (stable & ~prev_q) | (~stable & prev_q & sel_q);
    end

    clr    = '0;
    mask_d = mask_q;
    sel_d  = sel_q;
    if (wr_acc) begin
      case (avs.address)
        ADDR_MASK: mask_d = wdat;
        ADDR_CAP:  clr    = wdat;
        ADDR_SEL:  sel_d  = wdat;
        default:   ;
      endcase
    end

    // A new edge in the same cycle as its clear keeps the bit set.
    cap_d = (cap_q & ~clr) | edge_det;
    irq_d = |(cap_q & mask_q);

    rdata_d = rdata_q;
    if (rd_acc) begin
      case (avs.address)
        ADDR_DATA: rdata_d = 32'(stable);
        ADDR_MASK: rdata_d = 32'(mask_q);
        ADDR_CAP:  rdata_d = 32'(cap_q);
        ADDR_SEL:  rdata_d = 32'(sel_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt_q <= '0;
      prev_q      <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
      sel_q       <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      prime_cnt_q <= prime_cnt_d;
      prev_q      <= stable;
      mask_q      <= mask_d;
      cap_q       <= cap_d;
      sel_q       <= sel_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign avs.readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_soc_system_gpio_in_capture.sv
// Bench for soc_system_gpio_in_capture: reads push expected data into a scoreboard,
// a monitor pops and compares one clock after each accepted read.
`timescale 1ns/1ps
module tb_soc_system_gpio_in_capture;
  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  soc_system_gpio_in_capture_if bus ();

  soc_system_gpio_in_capture #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [31:0] mon_exp;
  string       mon_nm;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = a;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    @(negedge clk);
  endtask

  // Monitor: readdata is checked shortly after the edge that accepted the read.
  always @(posedge clk) begin
    if (reset_n && bus.chipselect && !bus.read_n) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got a read with an empty scoreboard, required none");
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = nm_q.pop_front();
        #2 check(mon_nm, bus.readdata, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: simulation exceeded 200000 ns, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bus_idle();
    bus.address   = 2'd0;
    bus.writedata = 32'h0;
    reset_n       = 1'b0;
`ifdef GPIO_IN_DEBOUNCE_EN
    in_port = 24'h000000;
`else
    in_port = 24'h000001;
`endif
    wait_clk(3);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;

`ifdef GPIO_IN_DEBOUNCE_EN
    wait_clk(20);
    check("deb_irq_idle", {31'h0, irq}, 32'h0);
    // One prescaler period high: seen by exactly one tick.
    in_port = 24'h000001;
    wait_clk(4);
    in_port = 24'h000000;
    wait_clk(20);
    bus_read(2'd0, 32'h0, "glitch_data");
    bus_read(2'd2, 32'h0, "glitch_cap");
    bus_idle();
    in_port = 24'h000001;
    wait_clk(15);
    bus_read(2'd0, 32'h1, "deb_data");
    bus_idle();
    wait_clk(5);
    bus_read(2'd2, 32'h1, "deb_cap");
    bus_idle();
    in_port = 24'h000000;
`else
    // Bit 0 was high through reset: visible in DATA, never captured.
    wait_clk(5);
    check("irq_after_prime", {31'h0, irq}, 32'h0);
    bus_read(2'd0, 32'h000001, "data_at_reset");
    bus_read(2'd2, 32'h000000, "cap_after_prime");
    bus_idle();

    // Rising-only capture on bit 4, irq one clock behind EDGE_CAP.
    bus_write(2'd3, 32'h0);
    bus_write(2'd1, 32'h10);
    bus_idle();
    in_port = 24'h000011;
    wait_clk(3);
    check("irq_lag", {31'h0, irq}, 32'h0);
    bus_read(2'd2, 32'h10, "cap_rise");
    bus_idle();
    check("irq_rise", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 32'h10);
    bus_idle();
    in_port = 24'h000001;
    wait_clk(4);
    bus_read(2'd2, 32'h0, "cap_fall_ignored");
    bus_idle();
    check("irq_clear", {31'h0, irq}, 32'h0);

    // Any-edge capture; falling edge lands in the same cycle as the clear.
    bus_write(2'd3, 32'h10);
    bus_idle();
    in_port = 24'h000011;
    wait_clk(4);
    bus_read(2'd2, 32'h10, "cap_any_rise");
    bus_idle();
    in_port = 24'h000001;
    wait_clk(2);
    bus_write(2'd2, 32'h10);
    bus_idle();
    bus_read(2'd2, 32'h10, "set_wins");
    bus_idle();
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 32'h10);
    bus_idle();
    check("irq_hold", {31'h0, irq}, 32'h1);
    wait_clk(1);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    bus_read(2'd2, 32'h0, "cap_cleared");
    bus_idle();

    // Masked capture on the top bit, then unmask.
    bus_write(2'd1, 32'h0);
    bus_idle();
    in_port = 24'h800001;
    wait_clk(4);
    bus_read(2'd2, 32'h800000, "cap_b23");
    bus_idle();
    wait_clk(1);
    check("irq_masked", {31'h0, irq}, 32'h0);
    bus_write(2'd1, 32'h800000);
    bus_idle();
    check("irq_mask_lag", {31'h0, irq}, 32'h0);
    wait_clk(1);
    check("irq_unmask", {31'h0, irq}, 32'h1);
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_read(2'd1, 32'h00FFFFFF, "mask_width");
    bus_idle();

    // Back-to-back reads and a write to the read-only DATA register.
    bus_read(2'd0, 32'h800001, "b2b_data");
    bus_read(2'd1, 32'h00FFFFFF, "b2b_mask");
    bus_read(2'd2, 32'h800000, "b2b_cap");
    bus_read(2'd3, 32'h10, "b2b_sel");
    bus_idle();
    bus_write(2'd0, 32'h123);
    bus_read(2'd0, 32'h800001, "data_ro");
    bus_idle();
    wait_clk(2);
    check("rd_hold", bus.readdata, 32'h800001);

    // Reset mid-operation: all state clears and priming restarts.
    reset_n = 1'b0;
    wait_clk(1);
    check("rerst_readdata", bus.readdata, 32'h0);
    check("rerst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    wait_clk(5);
    bus_read(2'd2, 32'h0, "cap_after_rerst");
    bus_read(2'd1, 32'h0, "mask_after_rerst");
    bus_read(2'd3, 32'h0, "sel_after_rerst");
    bus_read(2'd0, 32'h800001, "data_after_rerst");
    bus_idle();
`endif

    wait_clk(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d reads unanswered, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/soc_system_gpio_in_capture.md
Name: soc_system_gpio_in_capture

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the 24-bit output PIO on the HPS lightweight bridge.
- Samples external inputs (limit switches, encoder index, e-stop sense) and synchronises them into clk.
- Detects edges, latches them in a write-1-to-clear capture register and raises a maskable level interrupt to the HPS.
- Registered read path with fixed read latency of 1.

Parameters:
- WIDTH, 24, number of input bits; legal range 1..32.
- DEBOUNCE_CYCLES, 1000, clk cycles between debounce sample ticks; used only with GPIO_IN_DEBOUNCE_EN; minimum 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, valid 1 cycle after the accepted read.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active high.

Behaviour:
- Register map, unused upper bits read 0 and are ignored on write:
  - 0 DATA: read-only, filtered input value; writes ignored.
  - 1 IRQ_MASK: read/write, bit=1 enables that bit's capture to drive irq.
  - 2 EDGE_CAP: read; writing 1 clears a bit, writing 0 leaves it unchanged.
  - 3 EDGE_SEL: read/write, bit=1 captures any edge, bit=0 captures rising edge only.
- Reset: readdata=0, irq=0; IRQ_MASK, EDGE_CAP, EDGE_SEL, synchroniser, filtered value and previous value all 0.
- Write accepted when chipselect=1 and write_n=0; takes effect at that clock edge.
- Read accepted when chipselect=1 and read_n=0; readdata is registered from the addressed register on that edge.
  - readdata holds its value when no read is accepted.
  - Reading EDGE_CAP has no side effect.
- Synchroniser: 2 flops per bit. sync = in_port delayed 2 clk.
- Filtered value: stable = sync when debounce is compiled out.
- Edge detect: prev <= stable every cycle.
  - rise = stable & ~prev; fall = ~stable & prev.
  - edge = rise | (fall & EDGE_SEL).
- Priming: edge detection is suppressed until a primed flag sets, 3 cycles after reset_n deasserts.
  - Before priming, prev still tracks stable.
  - Inputs already high at reset therefore generate no capture.
- Capture: EDGE_CAP[i] <= (EDGE_CAP[i] & ~clr[i]) | edge[i].
  - clr is writedata on an accepted address-2 write.
  - Set and clear in the same cycle: set wins, bit ends at 1.
- irq: registered, irq <= |(EDGE_CAP & IRQ_MASK), so 1 cycle behind the register state.
- Latency with debounce off: in_port rising to EDGE_CAP set is 3 clk edges; irq follows 1 clk later.
- Reset asserted mid-operation clears all state immediately.
  - After release, priming restarts.
  - A read outstanding at reset returns 0.

Optional Feature:
- Macro: GPIO_IN_DEBOUNCE_EN.
- When defined:
  - A prescaler counter (width clog2(DEBOUNCE_CYCLES)) counts 0..DEBOUNCE_CYCLES-1 and wraps; a tick fires on the wrap.
  - On each tick, each bit shifts sync into a 3-deep history.
  - stable[i] updates only when all 3 history samples agree; otherwise it holds.
  - Worst-case acceptance delay: 2 clk + 3*DEBOUNCE_CYCLES.
  - Pulses shorter than 2 ticks never change stable.
  - Prescaler and history reset to 0. Priming additionally waits for the first 3 ticks.
- When undefined: no prescaler or history logic; stable = sync; DEBOUNCE_CYCLES is unused.

Test Plan:
- Reset with in_port=0x000001 held high; release; read address 0 after 5 clk -> readdata=0x000001; EDGE_CAP reads 0; irq=0.
- EDGE_SEL=0, IRQ_MASK=0x000010; drive in_port[4] 0->1 -> EDGE_CAP=0x000010 3 clk later, irq=1 1 clk after that; drive in_port[4] 1->0 -> no new capture.
- EDGE_SEL=0x000010; capture an edge on bit 4; write 0x000010 to address 2 in the same cycle as a new edge on bit 4 -> EDGE_CAP stays 0x000010. Write 0x000010 again with no edge -> EDGE_CAP=0, irq=0 one cycle later.
- IRQ_MASK=0; edge on bit 23 -> EDGE_CAP=0x800000, irq stays 0. Write IRQ_MASK=0x800000 -> irq=1 next cycle. Write 0xFFFFFFFF to address 1 -> reads back 0x00FFFFFF.
- Back-to-back reads of addresses 0,1,2,3 on consecutive cycles -> each readdata correct 1 cycle after its read; write to address 0 -> no register change.
- With GPIO_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
  - 1-tick-wide glitch on bit 0 -> no DATA change, no capture.
  - 20 clk high level -> DATA[0]=1 within 2+12 clk, EDGE_CAP[0]=1.
